// File: rtl/pipe_stage_ctrl.sv
// Pipeline stage-register control for a 5-stage core: PC enable/select,
// per-stage load/hold/valid, and LM/SM micro-op sequencing with a stall counter.
module pipe_stage_ctrl #(
   parameter int MASK_W = 8,
   parameter int IDX_W  = 3
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              stall_req,
   input  logic              flush_req,
   input  logic              lmsm_start,
   input  logic [MASK_W-1:0] lmsm_mask,
   output logic              pc_en,
   output logic              pc_sel,
   output logic [4:0]        ld,
   output logic [4:0]        hold,
   output logic [4:0]        valid,
   output logic              lmsm_active,
   output logic [IDX_W-1:0]  lmsm_idx,
   output logic [15:0]       stall_cnt
);

   typedef enum logic {
      RUN  = 1'b0,
      LMSM = 1'b1
   } state_t;

   localparam logic [4:0] LD_ALL   = 5'b11111;
   localparam logic [4:0] LD_STALL = 5'b11011;
   localparam logic [4:0] LD_FLUSH = 5'b11000;
   localparam logic [4:0] HOLD_FE  = 5'b00011;

   state_t            state;
   state_t            state_nxt;
   logic [MASK_W-1:0] rem;
   logic [MASK_W-1:0] rem_nxt;
   logic [MASK_W-1:0] src;
   logic [MASK_W-1:0] low_bit;
   logic [MASK_W-1:0] left;
   logic              issue_ok;
   logic              cnt_inc;
   logic              pc_en_c;
   logic              pc_sel_c;
   logic [4:0]        ld_c;
   logic [4:0]        hold_c;
   logic              act_c;
   logic [IDX_W-1:0]  idx_c;
   logic [4:0]        valid_nxt;

   function automatic logic [IDX_W-1:0] low_idx(input logic [MASK_W-1:0] m);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = MASK_W - 1; i >= 0; i--) begin
         if (m[i]) r = i[IDX_W-1:0];
      end
      return r;
   endfunction

   // Micro-ops come from the incoming mask in RUN and from the remainder in LMSM.
   always_comb begin
      src      = (state == LMSM) ? rem : lmsm_mask;
      low_bit  = src & ~(src - MASK_W'(1));
      left     = src & ~low_bit;
      issue_ok = (state == LMSM) ? (|rem) : (lmsm_start && (|lmsm_mask));
   end

   always_comb begin
      pc_en_c   = 1'b1;
      pc_sel_c  = 1'b0;
      ld_c      = LD_ALL;
      hold_c    = '0;
      act_c     = 1'b0;
      idx_c     = '0;
      state_nxt = state;
      rem_nxt   = rem;
      cnt_inc   = 1'b0;
      if (flush_req) begin
         pc_sel_c  = 1'b1;
         ld_c      = LD_FLUSH;
         state_nxt = RUN;
         rem_nxt   = '0;
      end else if (stall_req) begin
         pc_en_c = 1'b0;
         ld_c    = LD_STALL;
         hold_c  = HOLD_FE;
         cnt_inc = 1'b1;
      end else if (issue_ok) begin
         act_c   = 1'b1;
         idx_c   = low_idx(src);
         rem_nxt = left;
         if (|left) begin
            pc_en_c   = 1'b0;
            hold_c    = HOLD_FE;
            state_nxt = LMSM;
            cnt_inc   = 1'b1;
         end else begin
            state_nxt = RUN;
         end
      end else if (state == LMSM) begin
         // An empty remainder in LMSM cannot arise normally; fall back to RUN.
         state_nxt = RUN;
         rem_nxt   = '0;
      end
   end

   always_comb begin
      for (int k = 0; k < 5; k++) begin
         if (!ld_c[k])     valid_nxt[k] = 1'b0;
         else if (hold_c[k]) valid_nxt[k] = valid[k];
         else if (k == 0)  valid_nxt[k] = 1'b1;
         else              valid_nxt[k] = valid[k-1];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= RUN;
         rem       <= '0;
         valid     <= '0;
         stall_cnt <= '0;
      end else begin
         state <= state_nxt;
         rem   <= rem_nxt;
         valid <= valid_nxt;
         if (cnt_inc && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      end
   end

   // Control outputs are forced quiet while reset is held.
   assign pc_en       = resetn & pc_en_c;
   assign pc_sel      = resetn & pc_sel_c;
   assign ld          = resetn ? ld_c : 5'b00000;
   assign hold        = resetn ? hold_c : 5'b00000;
   assign lmsm_active = resetn & act_c;
   assign lmsm_idx    = (resetn && act_c) ? idx_c : '0;

endmodule
